// File: rtl/mau_pkg.sv
// Shared state encoding, op codes and default widths for the memory access unit.
package mau_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } mau_state_e;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefAddrW = 3;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the data memory: one request at a time, loads answer
// over a valid/ready response. Optional MAU_BOUNDS_CHECK_EN faults out-of-range addresses.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [DATA_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic [2:0]        req_rd_i,
   output logic              mem_load_o,
   output logic              mem_store_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_data_o,
   output logic [2:0]        resp_rd_o,
   output logic              resp_err_o,
   output logic              st_done_o
);

   // MEM_LAT is at most 4, so the remaining-wait count fits in two bits.
   localparam int unsigned CntW = 2;

   mau_state_e        state_q;
   logic              we_q;
   logic [CntW-1:0]   cnt_q;
   logic              req_ready_q;
   logic              mem_load_q;
   logic              mem_store_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_data_q;
   logic [2:0]        resp_rd_q;
   logic              resp_err_q;
   logic              st_done_q;
   logic              req_fault;

`ifdef MAU_BOUNDS_CHECK_EN
   assign req_fault  = |req_addr_i[DATA_W-1:ADDR_W];
   assign resp_err_o = resp_err_q;
`else
   logic unused_bounds;
   assign req_fault     = 1'b0;
   assign resp_err_o    = 1'b0;
   assign unused_bounds = ^{req_addr_i[DATA_W-1:ADDR_W], resp_err_q};
`endif

   // Strobes are set on the accept edge so they are high exactly during the ISSUE cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         we_q         <= 1'b0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         mem_load_q   <= 1'b0;
         mem_store_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_rd_q    <= '0;
         resp_err_q   <= 1'b0;
         st_done_q    <= 1'b0;
      end else begin
         mem_load_q  <= 1'b0;
         mem_store_q <= 1'b0;
         st_done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  req_ready_q <= 1'b0;
                  we_q        <= req_we_i;
                  mem_addr_q  <= req_addr_i[ADDR_W-1:0];
                  mem_wdata_q <= req_wdata_i;
                  resp_rd_q   <= req_rd_i;
                  if (req_fault) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_data_q  <= '0;
                     // Faulting store still passes through ISSUE for its one-cycle response.
                     state_q      <= (req_we_i == OP_STORE) ? StIssue : StResp;
                  end else begin
                     mem_store_q <= (req_we_i == OP_STORE);
                     st_done_q   <= (req_we_i == OP_STORE);
                     mem_load_q  <= (req_we_i == OP_LOAD);
                     state_q     <= StIssue;
                  end
               end
            end
            StIssue: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               if (we_q == OP_STORE) begin
                  req_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  cnt_q   <= CntW'(MEM_LAT - 1);
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  resp_data_q  <= mem_rdata_i;
                  resp_valid_q <= 1'b1;
                  state_q      <= StResp;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StResp: begin
               if (resp_ready_i) begin
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: begin
               req_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign mem_load_o   = mem_load_q;
   assign mem_store_o  = mem_store_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign resp_rd_o    = resp_rd_q;
   assign st_done_o    = st_done_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a latency-1 instance with a memory model and scoreboard,
// plus a latency-3 instance driven directly to pin down the capture cycle.
module tb_mem_access_unit;
   import mau_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [2:0]    rd;
      logic          err;
   } resp_t;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_we;
   logic [DW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [2:0]    req_rd;
   logic          resp_ready;

   logic          req_ready, mem_load, mem_store, resp_valid, resp_err, st_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, resp_data;
   logic [2:0]    resp_rd;

   logic          req_valid3;
   logic [DW-1:0] rdata3;
   logic          req_ready3, mem_load3, mem_store3, resp_valid3, resp_err3, st_done3;
   logic [AW-1:0] mem_addr3;
   logic [DW-1:0] mem_wdata3, resp_data3;
   logic [2:0]    resp_rd3;

   int            checks;
   int            errors;
   resp_t         sb[$];
   logic [DW-1:0] exp_mem [8];
   logic [DW-1:0] mem [8];
   logic          prev_load, prev_store;

   mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_rd_i    (req_rd),
      .mem_load_o  (mem_load),
      .mem_store_o (mem_store),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata),
      .resp_valid_o(resp_valid),
      .resp_ready_i(resp_ready),
      .resp_data_o (resp_data),
      .resp_rd_o   (resp_rd),
      .resp_err_o  (resp_err),
      .st_done_o   (st_done)
   );

   mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3)) u_dut3 (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid3),
      .req_ready_o (req_ready3),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_rd_i    (req_rd),
      .mem_load_o  (mem_load3),
      .mem_store_o (mem_store3),
      .mem_addr_o  (mem_addr3),
      .mem_wdata_o (mem_wdata3),
      .mem_rdata_i (rdata3),
      .resp_valid_o(resp_valid3),
      .resp_ready_i(resp_ready),
      .resp_data_o (resp_data3),
      .resp_rd_o   (resp_rd3),
      .resp_err_o  (resp_err3),
      .st_done_o   (st_done3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latency-1 data memory: read data valid the cycle after the LOAD strobe.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
         mem_rdata <= '0;
      end else begin
         if (mem_store) mem[mem_addr] <= mem_wdata;
         if (mem_load) mem_rdata <= mem[mem_addr];
      end
   end

   // Response scoreboard and strobe-shape monitor.
   always @(negedge clk) begin
      resp_t exp_r;
      if (!rst && resp_valid && resp_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got data=%h rd=%0d err=%0b, required no response",
                     resp_data, resp_rd, resp_err);
         end else begin
            exp_r = sb.pop_front();
            if ({resp_data, resp_rd, resp_err} !== exp_r) begin
               errors++;
               $display("FAIL resp_scoreboard: got data=%h rd=%0d err=%0b, required data=%h rd=%0d err=%0b",
                        resp_data, resp_rd, resp_err, exp_r.data, exp_r.rd, exp_r.err);
            end
         end
      end
      if (mem_load || mem_store) begin
         checks++;
         if ((mem_load && mem_store) || (mem_load && prev_load) || (mem_store && prev_store)) begin
            errors++;
            $display("FAIL strobe_shape: got load=%0b store=%0b prev_load=%0b prev_store=%0b, required single non-overlapping pulses",
                     mem_load, mem_store, prev_load, prev_store);
         end
      end
      prev_load  <= mem_load;
      prev_store <= mem_store;
   end

   task automatic init_exp_mem;
      for (int i = 0; i < 8; i++) exp_mem[i] = 16'h1000 + 16'(i);
   endtask

   task automatic send(input logic we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [2:0] rd);
      bit ok;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_rd    = rd;
      req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_accept: got req_ready=0 for 20 cycles, required 1");
      end
   endtask

   task automatic wait_idle;
      bit done;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (req_ready && !resp_valid) done = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL wait_idle: got req_ready=%0b resp_valid=%0b, required 1/0", req_ready, resp_valid);
      end
   endtask

   task automatic test_reset;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_valid3 = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_rd     = '0;
      resp_ready = 1'b1;
      rdata3     = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem_load, mem_store, mem_addr, mem_wdata, resp_valid, resp_data, resp_rd, resp_err,
           st_done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got load=%0b store=%0b addr=%0d wdata=%h rv=%0b rdata=%h rd=%0d err=%0b st=%0b, required all 0",
                  mem_load, mem_store, mem_addr, mem_wdata, resp_valid, resp_data, resp_rd,
                  resp_err, st_done);
      end
      checks++;
      if (req_ready !== 1'b1 || req_ready3 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %0b/%0b, required 1/1", req_ready, req_ready3);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid3 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got req_ready=%0b resp_valid3=%0b, required 1/0",
                  req_ready, resp_valid3);
      end
      init_exp_mem();
   endtask

   task automatic test_store_then_load;
      send(OP_STORE, 16'd3, 16'hA5A5, 3'd0);
      checks++;
      if (mem_store !== 1'b1 || st_done !== 1'b1 || mem_load !== 1'b0 || mem_addr !== 3'd3 ||
          mem_wdata !== 16'hA5A5) begin
         errors++;
         $display("FAIL store_issue: got store=%0b st_done=%0b load=%0b addr=%0d wdata=%h, required 1/1/0/3/a5a5",
                  mem_store, st_done, mem_load, mem_addr, mem_wdata);
      end
      exp_mem[3] = 16'hA5A5;
      @(posedge clk); #1;
      checks++;
      if (mem_store !== 1'b0 || st_done !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL store_done: got store=%0b st_done=%0b req_ready=%0b, required 0/0/1",
                  mem_store, st_done, req_ready);
      end
      sb.push_back({exp_mem[3], 3'd5, 1'b0});
      send(OP_LOAD, 16'd3, 16'h0000, 3'd5);
      checks++;
      if (mem_load !== 1'b1 || mem_addr !== 3'd3) begin
         errors++;
         $display("FAIL load_issue: got load=%0b addr=%0d, required 1/3", mem_load, mem_addr);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || mem_load !== 1'b0) begin
         errors++;
         $display("FAIL load_early: got resp_valid=%0b load=%0b one cycle after issue, required 0/0",
                  resp_valid, mem_load);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rd !== 3'd5) begin
         errors++;
         $display("FAIL load_latency: got resp_valid=%0b rd=%0d two cycles after accept, required 1/5",
                  resp_valid, resp_rd);
      end
      wait_idle();
   endtask

   task automatic test_backpressure;
      bit got;
      resp_ready = 1'b0;
      sb.push_back({exp_mem[5], 3'd2, 1'b0});
      send(OP_LOAD, 16'd5, 16'h0000, 3'd2);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         if (resp_valid) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bp_resp: got resp_valid=0 for 10 cycles, required 1");
      end
      req_we    = OP_STORE;
      req_addr  = 16'd6;
      req_wdata = 16'h6B6B;
      req_rd    = 3'd0;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== exp_mem[5] || resp_rd !== 3'd2 ||
             req_ready !== 1'b0 || mem_store !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got rv=%0b data=%h rd=%0d req_ready=%0b store=%0b, required 1/%h/2/0/0",
                     i, resp_valid, resp_data, resp_rd, req_ready, mem_store, exp_mem[5]);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_store !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got rv=%0b req_ready=%0b store=%0b, required 0/1/0",
                  resp_valid, req_ready, mem_store);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (mem_store !== 1'b1 || mem_addr !== 3'd6 || mem_wdata !== 16'h6B6B) begin
         errors++;
         $display("FAIL bp_second_req: got store=%0b addr=%0d wdata=%h, required 1/6/6b6b",
                  mem_store, mem_addr, mem_wdata);
      end
      exp_mem[6] = 16'h6B6B;
      wait_idle();
   endtask

   task automatic test_latency_sweep;
      req_we     = OP_LOAD;
      req_addr   = 16'd0;
      req_rd     = 3'd3;
      resp_ready = 1'b0;
      req_valid3 = 1'b1;
      rdata3     = 16'hBAD0;
      @(posedge clk); #1;
      req_valid3 = 1'b0;
      checks++;
      if (mem_load3 !== 1'b1 || mem_addr3 !== 3'd0) begin
         errors++;
         $display("FAIL lat3_issue: got load=%0b addr=%0d, required 1/0", mem_load3, mem_addr3);
      end
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid3 !== (k == 4)) begin
            errors++;
            $display("FAIL lat3_valid[%0d]: got resp_valid=%0b, required %0b", k, resp_valid3, k == 4);
         end
         rdata3 = (k == 3) ? 16'h3C3C : 16'hBAD0 + 16'(k);
      end
      checks++;
      if (resp_data3 !== 16'h3C3C || resp_rd3 !== 3'd3) begin
         errors++;
         $display("FAIL lat3_capture: got data=%h rd=%0d, required 3c3c/3", resp_data3, resp_rd3);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid3 !== 1'b1 || resp_data3 !== 16'h3C3C) begin
         errors++;
         $display("FAIL lat3_hold: got rv=%0b data=%h, required 1/3c3c", resp_valid3, resp_data3);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (resp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin
         errors++;
         $display("FAIL lat3_done: got rv=%0b req_ready=%0b, required 0/1", resp_valid3, req_ready3);
      end
   endtask

   task automatic test_addr_wrap;
`ifdef MAU_BOUNDS_CHECK_EN
      sb.push_back({16'h0000, 3'd1, 1'b1});
`else
      sb.push_back({exp_mem[1], 3'd1, 1'b0});
`endif
      send(OP_LOAD, 16'd9, 16'h0000, 3'd1);
      checks++;
`ifdef MAU_BOUNDS_CHECK_EN
      if (mem_load !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1) begin
         errors++;
         $display("FAIL addr_fault: got load=%0b rv=%0b err=%0b, required 0/1/1",
                  mem_load, resp_valid, resp_err);
      end
`else
      if (mem_load !== 1'b1 || mem_addr !== 3'd1) begin
         errors++;
         $display("FAIL addr_wrap: got load=%0b addr=%0d, required 1/1", mem_load, mem_addr);
      end
`endif
      wait_idle();
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] addrs [3];
      logic [DW-1:0] datas [3];
      addrs = '{16'd2, 16'd4, 16'd7};
      datas = '{16'h1234, 16'hBEEF, 16'h0F0F};
      req_we    = OP_STORE;
      req_rd    = 3'd0;
      req_addr  = addrs[0];
      req_wdata = datas[0];
      req_valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         checks++;
         if (mem_store !== 1'b1 || st_done !== 1'b1 || mem_addr !== addrs[n][AW-1:0] ||
             mem_wdata !== datas[n]) begin
            errors++;
            $display("FAIL b2b_issue[%0d]: got store=%0b st_done=%0b addr=%0d wdata=%h, required 1/1/%0d/%h",
                     n, mem_store, st_done, mem_addr, mem_wdata, addrs[n][AW-1:0], datas[n]);
         end
         exp_mem[addrs[n][AW-1:0]] = datas[n];
         if (n < 2) begin
            req_addr  = addrs[n+1];
            req_wdata = datas[n+1];
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
         checks++;
         if (mem_store !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap[%0d]: got store=%0b req_ready=%0b, required 0/1",
                     n, mem_store, req_ready);
         end
      end
      sb.push_back({exp_mem[4], 3'd6, 1'b0});
      send(OP_LOAD, 16'd4, 16'h0000, 3'd6);
      wait_idle();
   endtask

   task automatic test_reset_mid_load;
      send(OP_LOAD, 16'd2, 16'h0000, 3'd4);
      @(posedge clk); #1;
      checks++;
      if (mem_load !== 1'b0 || mem_addr !== 3'd2 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL wait_state: got load=%0b addr=%0d rv=%0b, required 0/2/0",
                  mem_load, mem_addr, resp_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({mem_load, mem_store, mem_addr, mem_wdata, resp_valid, resp_data, resp_rd, resp_err,
           st_done} !== '0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got load=%0b store=%0b addr=%0d rv=%0b rdata=%h req_ready=%0b, required 0/0/0/0/0/1",
                  mem_load, mem_store, mem_addr, resp_valid, resp_data, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      init_exp_mem();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL dropped_load[%0d]: got rv=%0b req_ready=%0b, required 0/1",
                     i, resp_valid, req_ready);
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      prev_load  = 1'b0;
      prev_store = 1'b0;
      test_reset();
      test_store_then_load();
      test_backpressure();
      test_latency_sweep();
      test_addr_wrap();
      test_back_to_back();
      test_reset_mid_load();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
